// File: rtl/sprite_draw_engine_pkg.sv
// Shared constants and types for the sprite draw engine.
// Screen limits, sprite selector codes and FSM states.
package sprite_draw_engine_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    localparam logic [8:0] TRANSPARENT_DEF = 9'h1C7;

    typedef enum logic [1:0] {
        SEL_GOLD    = 2'd0,
        SEL_STONE   = 2'd1,
        SEL_DIAMOND = 2'd2,
        SEL_HOOK    = 2'd3
    } sprite_sel_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_FLUSH,
        S_DONE
    } draw_state_e;

endpackage

// File: rtl/sprite_draw_engine_pixel.sv
// Pixel stage: lines up screen coordinates with the ROM colour
// one cycle after the address, then clips and keys out transparency.
module sprite_draw_engine_pixel
    import sprite_draw_engine_pkg::*;
#(
    parameter logic [8:0] TRANSPARENT = TRANSPARENT_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       issue,
    input  logic [9:0] sx,
    input  logic [8:0] sy,
    input  logic [8:0] rom_data,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [8:0] vga_colour,
    output logic       plot
);

    logic       valid;
    logic [9:0] px;
    logic [8:0] py;
    logic       on_screen;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid <= 1'b0;
            px    <= '0;
            py    <= '0;
        end else begin
            valid <= issue;
            px    <= sx;
            py    <= sy;
        end
    end

    // Wide sums keep off-screen pixels off-screen instead of wrapping.
    assign on_screen  = (px < 10'(SCREEN_W)) && (py < 9'(SCREEN_H));
    assign vga_x      = px[8:0];
    assign vga_y      = py[7:0];
    assign vga_colour = valid ? rom_data : '0;
    assign plot       = valid && (rom_data != TRANSPARENT) && on_screen;

endmodule

// File: rtl/sprite_draw_engine.sv
// Sprite blitter: scans a sprite out of an external ROM and streams
// clipped, colour-keyed pixels to the VGA adapter.
module sprite_draw_engine
    import sprite_draw_engine_pkg::*;
#(
    parameter int         SPRITE_W    = 16,
    parameter int         SPRITE_H    = 16,
    parameter logic [8:0] TRANSPARENT = TRANSPARENT_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic [8:0] x_origin,
    input  logic [7:0] y_origin,
    input  logic [1:0] sprite_sel,
    output logic [9:0] rom_addr,
    input  logic [8:0] rom_data,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [8:0] vga_colour,
    output logic       plot,
    output logic       done
);

    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);

    draw_state_e   state;
    logic [8:0]    x_lat;
    logic [7:0]    y_lat;
    logic [1:0]    sel_lat;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_end;
    logic          last;

    assign col_end = (col == CW'(SPRITE_W - 1));
    assign last    = col_end && (row == RW'(SPRITE_H - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= S_IDLE;
            x_lat   <= '0;
            y_lat   <= '0;
            sel_lat <= '0;
            col     <= '0;
            row     <= '0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (enable) begin
                        x_lat   <= x_origin;
                        y_lat   <= y_origin;
                        sel_lat <= sprite_sel;
                        col     <= '0;
                        row     <= '0;
                        state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else begin
                        col <= col + 1'b1;
                        if (col_end) row <= row + 1'b1;
                        if (last) state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    state <= enable ? S_DONE : S_IDLE;
                    done  <= enable;
                end
                S_DONE: begin
                    if (!enable) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr = 10'({sel_lat, row, col});

    sprite_draw_engine_pixel #(
        .TRANSPARENT(TRANSPARENT)
    ) u_pixel (
        .clk       (clk),
        .resetn    (resetn),
        .issue     ((state == S_SCAN) && enable),
        .sx        (10'(x_lat) + 10'(col)),
        .sy        (9'(y_lat) + 9'(row)),
        .rom_data  (rom_data),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .plot      (plot)
    );

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed bench for sprite_draw_engine with a registered ROM model.
module tb_sprite_draw_engine;

    logic       clk = 1'b0;
    logic       resetn;
    logic       enable;
    logic [8:0] x_origin;
    logic [7:0] y_origin;
    logic [1:0] sprite_sel;
    logic [9:0] rom_addr;
    logic [8:0] rom_data;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [8:0] vga_colour;
    logic       plot;
    logic       done;

    logic [8:0] mem [1024];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= mem[rom_addr];

    sprite_draw_engine dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .x_origin  (x_origin),
        .y_origin  (y_origin),
        .sprite_sel(sprite_sel),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .plot      (plot),
        .done      (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic fill(input logic [1:0] sel, input logic [8:0] a,
                        input logic [8:0] b);
        for (int i = 0; i < 256; i++) begin
            mem[{sel, i[7:0]}] = (i[4] ^ i[0]) ? b : a;
        end
    endtask

    // Runs one draw from IDLE; cycle 1 is the one after enable is sampled.
    task automatic run_draw(input logic [1:0] sel, input logic [8:0] x,
                            input logic [7:0] y, input logic [8:0] col,
                            output int nplots, output int done_cyc,
                            output int minx, output int maxx,
                            output int miny, output int maxy,
                            output int badcol);
        nplots = 0; done_cyc = 0; badcol = 0;
        minx = 999; maxx = -1; miny = 999; maxy = -1;
        sprite_sel = sel; x_origin = x; y_origin = y;
        enable = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            step();
            x_origin = 9'd0;
            y_origin = 8'd0;
            sprite_sel = ~sel;
            if (plot) begin
                nplots++;
                if (int'(vga_x) < minx) minx = int'(vga_x);
                if (int'(vga_x) > maxx) maxx = int'(vga_x);
                if (int'(vga_y) < miny) miny = int'(vga_y);
                if (int'(vga_y) > maxy) maxy = int'(vga_y);
                if (vga_colour !== col) badcol++;
            end
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; enable = 1'b0;
        x_origin = '0; y_origin = '0; sprite_sel = '0;
        step(); step(); step();
        n_cmp++;
        if ({plot, done, rom_addr, vga_x, vga_y, vga_colour} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required 0",
                     {plot, done, rom_addr, vga_x, vga_y, vga_colour});
        end
        resetn = 1'b1;
        idle(2);
    endtask

    task automatic test_solid();
        int np, dc, x0, x1, y0, y1, bc;
        fill(2'd0, 9'h1F8, 9'h1F8);
        run_draw(2'd0, 9'd100, 8'd50, 9'h1F8, np, dc, x0, x1, y0, y1, bc);
        n_cmp++;
        if (np !== 256) begin
            n_bad++; $display("FAIL solid_plots: got %0d required 256", np);
        end
        n_cmp++;
        if (dc !== 258) begin
            n_bad++; $display("FAIL solid_done: got %0d required 258", dc);
        end
        n_cmp++;
        if (x0 !== 100 || x1 !== 115 || y0 !== 50 || y1 !== 65) begin
            n_bad++;
            $display("FAIL solid_extent: got x %0d..%0d y %0d..%0d required x 100..115 y 50..65",
                     x0, x1, y0, y1);
        end
        n_cmp++;
        if (bc !== 0) begin
            n_bad++; $display("FAIL solid_colour: got %0d bad required 0", bc);
        end
        n_cmp++;
        if (plot !== 1'b0) begin
            n_bad++; $display("FAIL solid_plot_in_done: got %b required 0", plot);
        end
        idle(2);
    endtask

    task automatic test_transparency();
        int np, dc, x0, x1, y0, y1, bc;
        fill(2'd1, 9'h1C7, 9'h038);
        run_draw(2'd1, 9'd20, 8'd30, 9'h038, np, dc, x0, x1, y0, y1, bc);
        n_cmp++;
        if (np !== 128) begin
            n_bad++; $display("FAIL transp_plots: got %0d required 128", np);
        end
        n_cmp++;
        if (bc !== 0) begin
            n_bad++; $display("FAIL transp_colour: got %0d bad required 0", bc);
        end
        idle(2);
    endtask

    task automatic test_clipping();
        int np, dc, x0, x1, y0, y1, bc;
        fill(2'd3, 9'h0AA, 9'h0AA);
        run_draw(2'd3, 9'd310, 8'd235, 9'h0AA, np, dc, x0, x1, y0, y1, bc);
        n_cmp++;
        if (np !== 50) begin
            n_bad++; $display("FAIL clip_plots: got %0d required 50", np);
        end
        n_cmp++;
        if (dc !== 258) begin
            n_bad++; $display("FAIL clip_done: got %0d required 258", dc);
        end
        n_cmp++;
        if (x0 !== 310 || x1 !== 319 || y0 !== 235 || y1 !== 239) begin
            n_bad++;
            $display("FAIL clip_extent: got x %0d..%0d y %0d..%0d required x 310..319 y 235..239",
                     x0, x1, y0, y1);
        end
        idle(2);
    endtask

    task automatic test_abort();
        int plots_after, dones;
        fill(2'd2, 9'h011, 9'h011);
        sprite_sel = 2'd0; x_origin = 9'd5; y_origin = 8'd5;
        enable = 1'b1;
        for (int c = 1; c <= 40; c++) step();
        enable = 1'b0;
        step();
        n_cmp++;
        if (plot !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_c41: got plot %b done %b required 0 0", plot, done);
        end
        sprite_sel = 2'd2; x_origin = 9'd0; y_origin = 8'd0;
        enable = 1'b1;
        step();
        n_cmp++;
        if (rom_addr !== 10'h200) begin
            n_bad++; $display("FAIL abort_restart_addr: got %h required 200", rom_addr);
        end
        enable = 1'b0;
        plots_after = 0; dones = 0;
        for (int c = 0; c < 300; c++) begin
            step();
            if (plot) plots_after++;
            if (done) dones++;
        end
        n_cmp++;
        if (plots_after !== 0 || dones !== 0) begin
            n_bad++;
            $display("FAIL abort_quiet: got plots %0d dones %0d required 0 0",
                     plots_after, dones);
        end
    endtask

    task automatic test_handshake();
        int np, dc, x0, x1, y0, y1, bc;
        run_draw(2'd0, 9'd0, 8'd0, 9'h1F8, np, dc, x0, x1, y0, y1, bc);
        n_cmp++;
        if (dc !== 258) begin
            n_bad++; $display("FAIL hs_done: got %0d required 258", dc);
        end
        for (int k = 1; k <= 10; k++) begin
            step();
            n_cmp++;
            if (done !== 1'b1 || plot !== 1'b0) begin
                n_bad++;
                $display("FAIL hs_hold_%0d: got done %b plot %b required 1 0",
                         k, done, plot);
            end
        end
        enable = 1'b0;
        step();
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++; $display("FAIL hs_release: got %b required 0", done);
        end
        sprite_sel = 2'd3;
        enable = 1'b1;
        step();
        n_cmp++;
        if (rom_addr !== 10'h300) begin
            n_bad++; $display("FAIL hs_idle_restart: got %h required 300", rom_addr);
        end
        idle(3);
    endtask

    task automatic test_reset_mid_scan();
        int np, dc, x0, x1, y0, y1, bc;
        sprite_sel = 2'd0; x_origin = 9'd40; y_origin = 8'd40;
        enable = 1'b1;
        for (int c = 1; c <= 99; c++) step();
        resetn = 1'b0;
        enable = 1'b0;
        step();
        n_cmp++;
        if ({plot, done, rom_addr, vga_x, vga_y, vga_colour} !== '0) begin
            n_bad++;
            $display("FAIL midscan_reset: got %h required 0",
                     {plot, done, rom_addr, vga_x, vga_y, vga_colour});
        end
        resetn = 1'b1;
        step();
        run_draw(2'd0, 9'd200, 8'd100, 9'h1F8, np, dc, x0, x1, y0, y1, bc);
        n_cmp++;
        if (np !== 256 || dc !== 258) begin
            n_bad++;
            $display("FAIL midscan_redraw: got plots %0d done %0d required 256 258",
                     np, dc);
        end
        idle(2);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 9'h000;
        test_reset();
        test_solid();
        test_transparency();
        test_clipping();
        test_abort();
        test_handshake();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
